// File: rtl/fadd_sched.sv
// fadd_sched: shares one floating-point adder between the core FADD/FSUB
// issue path and the FMA multiply stage.
//
// Two-stage pipeline:
//   S1 - operand register; it drives the add_* outputs into the adder.
//   S2 - result register; it captures add_result_i and drives res_*.
// Accepting a request in cycle N gives res_valid_o in cycle N+2. The
// pipeline sustains one request per cycle.
//
// Ports:
//   clk_i, rstn_i, flush_i       clock, async active-low reset, sync kill
//   core_* (valid/ready)         FADD/FSUB requests; core_sub_i flips the sign of b
//   fma_*  (valid/ready)         addend + rounded product from the FMA multiplier
//   add_*_o / add_result_i       operands to and result from the shared adder
//   res_* (valid/ready)          result, tag and source (0 core, 1 FMA) to writeback
module fadd_sched #(
    parameter int FLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic            core_valid_i,
    output logic            core_ready_o,
    input  logic [FLEN-1:0] core_a_i,
    input  logic [FLEN-1:0] core_b_i,
    input  logic            core_sub_i,
    input  logic [2:0]      core_rm_i,
    input  logic [TAGW-1:0] core_tag_i,
    input  logic            fma_valid_i,
    output logic            fma_ready_o,
    input  logic [FLEN-1:0] fma_a_i,
    input  logic [FLEN-1:0] fma_b_i,
    input  logic [2:0]      fma_rm_i,
    input  logic            fma_prodInf_i,
    input  logic [TAGW-1:0] fma_tag_i,
    output logic [FLEN-1:0] add_a_o,
    output logic [FLEN-1:0] add_b_o,
    output logic [2:0]      add_rm_o,
    output logic            add_isFma_o,
    output logic            add_rs1rs2Inf_o,
    input  logic [FLEN-1:0] add_result_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [FLEN-1:0] res_o,
    output logic [TAGW-1:0] res_tag_o,
    output logic            res_src_o
);

    localparam int EXPW = (FLEN == 64) ? 11 : 8;
    localparam int MANW = FLEN - 1 - EXPW;

    logic            valid1;
    logic            valid2;
    logic [TAGW-1:0] tag1;
    logic            src1;
    logic            last_grant;  // 0 = core, 1 = FMA
    logic            adv1;
    logic            adv2;
    logic            grant_core;
    logic            grant_fma;
    logic            b_is_nan;
    logic [FLEN-1:0] core_b_eff;

    assign adv2 = !valid2 || res_ready_i;
    assign adv1 = !valid1 || adv2;

    // On a tie, the requester that did not win last time is granted.
    // last_grant resets to core, so FMA wins the first tie.
    assign grant_core = core_valid_i && (!fma_valid_i || last_grant);
    assign grant_fma  = fma_valid_i && (!core_valid_i || !last_grant);

    assign core_ready_o = adv1 && !flush_i && grant_core;
    assign fma_ready_o  = adv1 && !flush_i && grant_fma;

    // FSUB becomes an add with b negated. A NaN b keeps its sign bit so
    // that the NaN payload reaches the adder unchanged.
    assign b_is_nan   = (&core_b_i[FLEN-2:MANW]) && (|core_b_i[MANW-1:0]);
    assign core_b_eff = (core_sub_i && !b_is_nan) ?
                        {~core_b_i[FLEN-1], core_b_i[FLEN-2:0]} : core_b_i;

    assign res_valid_o = valid2;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid1          <= 1'b0;
            valid2          <= 1'b0;
            tag1            <= '0;
            src1            <= 1'b0;
            last_grant      <= 1'b0;
            add_a_o         <= '0;
            add_b_o         <= '0;
            add_rm_o        <= '0;
            add_isFma_o     <= 1'b0;
            add_rs1rs2Inf_o <= 1'b0;
            res_o           <= '0;
            res_tag_o       <= '0;
            res_src_o       <= 1'b0;
        end else if (flush_i) begin
            valid1 <= 1'b0;
            valid2 <= 1'b0;
        end else begin
            if (adv2) begin
                valid2 <= valid1;
                if (valid1) begin
                    res_o     <= add_result_i;
                    res_tag_o <= tag1;
                    res_src_o <= src1;
                end
            end
            if (core_ready_o) begin
                valid1          <= 1'b1;
                tag1            <= core_tag_i;
                src1            <= 1'b0;
                last_grant      <= 1'b0;
                add_a_o         <= core_a_i;
                add_b_o         <= core_b_eff;
                add_rm_o        <= core_rm_i;
                add_isFma_o     <= 1'b0;
                add_rs1rs2Inf_o <= 1'b0;
            end else if (fma_ready_o) begin
                valid1          <= 1'b1;
                tag1            <= fma_tag_i;
                src1            <= 1'b1;
                last_grant      <= 1'b1;
                add_a_o         <= fma_a_i;
                add_b_o         <= fma_b_i;
                add_rm_o        <= fma_rm_i;
                add_isFma_o     <= 1'b1;
                add_rs1rs2Inf_o <= fma_prodInf_i;
            end else if (adv1) begin
                // S1 drains. The operand registers keep their last value.
                valid1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fadd_sched.sv
module tb_fadd_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush, core_valid, core_sub, fma_valid, fma_inf, res_ready;
    logic [31:0] core_a, core_b, fma_a, fma_b;
    logic [2:0]  core_rm, fma_rm;
    logic [4:0]  core_tag, fma_tag;
    logic        core_ready, fma_ready, add_isfma, add_inf, res_valid, res_src;
    logic [31:0] add_a, add_b, add_result, res;
    logic [2:0]  add_rm;
    logic [4:0]  res_tag;

    always #5 clk = ~clk;

    fadd_sched #(.FLEN(32), .TAGW(5)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .core_valid_i(core_valid), .core_ready_o(core_ready),
        .core_a_i(core_a), .core_b_i(core_b), .core_sub_i(core_sub),
        .core_rm_i(core_rm), .core_tag_i(core_tag),
        .fma_valid_i(fma_valid), .fma_ready_o(fma_ready),
        .fma_a_i(fma_a), .fma_b_i(fma_b), .fma_rm_i(fma_rm),
        .fma_prodInf_i(fma_inf), .fma_tag_i(fma_tag),
        .add_a_o(add_a), .add_b_o(add_b), .add_rm_o(add_rm),
        .add_isFma_o(add_isfma), .add_rs1rs2Inf_o(add_inf),
        .add_result_i(add_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_o(res), .res_tag_o(res_tag), .res_src_o(res_src)
    );

    // Stand-in for the combinational adder.
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] rm, input logic f, input logic inf);
        if (a == 32'h3F800000 && b == 32'h40000000 && rm == 3'd0 && !f)
            return 32'h40400000;
        return (a + b) ^ {27'd0, inf, f, rm};
    endfunction

    assign add_result = fadd_model(add_a, add_b, add_rm, add_isfma, add_inf);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic        f;
        logic        inf;
        logic [4:0]  tag;
        logic        src;
        int          acc;
    } item_t;

    // Transaction-level reference: in-order queue of unretired requests.
    item_t q[$];
    item_t last_acc;
    bit    mlast;        // 1 when FMA was the last requester accepted
    int    cyc;
    bit    exp_rvalid, exp_cready, exp_fready;
    int    nvec = 0;
    int    nerr = 0;

    function automatic bit is_nan(input logic [31:0] b);
        return (((b >> 23) & 32'hFF) == 32'hFF) && ((b & 32'h007FFFFF) != 0);
    endfunction

    function automatic item_t make_core();
        item_t it;
        it.a   = core_a;
        it.b   = (core_sub && !is_nan(core_b)) ? (core_b ^ 32'h80000000) : core_b;
        it.rm  = core_rm;
        it.f   = 1'b0;
        it.inf = 1'b0;
        it.tag = core_tag;
        it.src = 1'b0;
        it.acc = 0;
        return it;
    endfunction

    function automatic item_t make_fma();
        item_t it;
        it.a   = fma_a;
        it.b   = fma_b;
        it.rm  = fma_rm;
        it.f   = 1'b1;
        it.inf = fma_inf;
        it.tag = fma_tag;
        it.src = 1'b1;
        it.acc = 0;
        return it;
    endfunction

    function automatic logic [31:0] head_result();
        return fadd_model(q[0].a, q[0].b, q[0].rm, q[0].f, q[0].inf);
    endfunction

    task automatic model_reset();
        q.delete();
        mlast       = 1'b0;
        last_acc    = '{default: '0};
        cyc         = 0;
    endtask

    // The head result is visible two cycles after its accept. With two
    // requests unretired and the consumer not ready, nothing is accepted.
    task automatic predict();
        bit any_rdy;
        exp_rvalid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
        any_rdy    = !flush && !(q.size() == 2 && !res_ready);
        exp_cready = any_rdy && core_valid && (!fma_valid || mlast);
        exp_fready = any_rdy && fma_valid && (!core_valid || !mlast);
    endtask

    task automatic advance();
        item_t it;
        it = exp_cready ? make_core() : make_fma();
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (exp_rvalid && res_ready) void'(q.pop_front());
            if (exp_cready || exp_fready) begin
                it.acc = cyc;
                q.push_back(it);
                last_acc = it;
                mlast = exp_fready;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; core_valid = 0; fma_valid = 0; res_ready = 1;
        core_a = 0; core_b = 0; core_sub = 0; core_rm = 0; core_tag = 0;
        fma_a = 0; fma_b = 0; fma_rm = 0; fma_inf = 0; fma_tag = 0;
    endtask

    task automatic rand_core();
        core_a = $urandom; core_b = $urandom; core_sub = 1'($urandom);
        core_rm = 3'($urandom); core_tag = 5'($urandom);
    endtask

    task automatic rand_fma();
        fma_a = $urandom; fma_b = $urandom; fma_rm = 3'($urandom);
        fma_inf = 1'($urandom); fma_tag = 5'($urandom);
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            predict();
            advance();
        end
    endtask

    task automatic apply_reset();
        idle();
        rstn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        predict();
        #1;
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        nvec++; if (res !== 32'd0 || res_tag !== 5'd0 || res_src !== 1'b0) begin nerr++; $display("FAIL reset_res got %h/%0d/%0b want 0", res, res_tag, res_src); end
        nvec++; if (add_a !== 32'd0 || add_b !== 32'd0 || add_rm !== 3'd0) begin nerr++; $display("FAIL reset_add_ops got %h %h %0d want 0", add_a, add_b, add_rm); end
        nvec++; if (add_isfma !== 1'b0 || add_inf !== 1'b0) begin nerr++; $display("FAIL reset_add_flags got %0b%0b want 00", add_isfma, add_inf); end
        nvec++; if (core_ready !== 1'b0 || fma_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready_no_req got %0b%0b want 00", core_ready, fma_ready); end
        advance();
    endtask

    task automatic test_single_fadd();
        idle();
        core_valid = 1; core_a = 32'h3F800000; core_b = 32'h40000000; core_rm = 0; core_tag = 5'd7;
        predict(); #1;
        nvec++; if (core_ready !== 1'b1) begin nerr++; $display("FAIL fadd_accept got %0b want 1", core_ready); end
        advance();
        idle();
        predict(); #1;
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL fadd_n1_valid got %0b want 0", res_valid); end
        nvec++; if (add_a !== 32'h3F800000 || add_b !== 32'h40000000 || add_isfma !== 1'b0) begin nerr++; $display("FAIL fadd_ops got %h %h %0b want 3f800000 40000000 0", add_a, add_b, add_isfma); end
        advance();
        predict(); #1;
        nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL fadd_n2_valid got %0b want 1", res_valid); end
        nvec++; if (res !== 32'h40400000 || res_src !== 1'b0 || res_tag !== 5'd7) begin nerr++; $display("FAIL fadd_result got %h src %0b tag %0d want 40400000 src 0 tag 7", res, res_src, res_tag); end
        advance();
        drain(2);
    endtask

    task automatic test_fsub();
        logic [31:0] bvals [3];
        logic [31:0] want [3];
        bvals[0] = 32'h40000000; want[0] = 32'hC0000000;
        bvals[1] = 32'h7FC00001; want[1] = 32'h7FC00001;
        bvals[2] = 32'h7F800000; want[2] = 32'hFF800000;
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k < 3) begin
                core_valid = 1; core_sub = 1; core_a = $urandom; core_b = bvals[k]; core_tag = 5'(k);
            end
            predict(); #1;
            if (k > 0) begin
                nvec++; if (add_b !== want[k-1]) begin nerr++; $display("FAIL fsub_b%0d got %h want %h", k-1, add_b, want[k-1]); end
            end
            advance();
        end
        drain(3);
    endtask

    task automatic test_tie();
        logic prev_inf;
        apply_reset();
        prev_inf = 0;
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                core_valid = 1; fma_valid = 1; rand_core(); rand_fma();
            end
            predict(); #1;
            if (k < 4) begin
                nvec++; if (fma_ready !== (k % 2 == 0) || core_ready !== (k % 2 == 1)) begin nerr++; $display("FAIL tie_grant%0d got fma %0b core %0b want fma %0b", k, fma_ready, core_ready, k % 2 == 0); end
            end
            if (k > 0) begin
                nvec++; if (add_isfma !== ((k - 1) % 2 == 0)) begin nerr++; $display("FAIL tie_isfma%0d got %0b want %0b", k - 1, add_isfma, (k - 1) % 2 == 0); end
                nvec++; if (add_inf !== (((k - 1) % 2 == 0) ? prev_inf : 1'b0)) begin nerr++; $display("FAIL tie_inf%0d got %0b", k - 1, add_inf); end
            end
            prev_inf = fma_inf;
            advance();
        end
        drain(3);
    endtask

    task automatic test_backpressure();
        int accepted, n_out;
        logic [31:0] held;
        idle();
        res_ready = 0; core_valid = 1; rand_core();
        accepted = 0; n_out = 0; held = 0;
        for (int c = 0; c < 5; c++) begin
            predict(); #1;
            nvec++; if (core_ready !== exp_cready) begin nerr++; $display("FAIL bp_ready%0d got %0b want %0b", c, core_ready, exp_cready); end
            if (c == 2) held = res;
            if (c > 2) begin
                nvec++; if (res !== held || res_valid !== 1'b1) begin nerr++; $display("FAIL bp_stable%0d got %h v%0b want %h v1", c, res, res_valid, held); end
            end
            if (core_ready) accepted++;
            advance();
            if (exp_cready) rand_core();
        end
        nvec++; if (accepted !== 2) begin nerr++; $display("FAIL bp_accept_count got %0d want 2", accepted); end
        res_ready = 1;
        for (int c = 0; c < 8; c++) begin
            predict(); #1;
            nvec++; if (res_valid !== exp_rvalid) begin nerr++; $display("FAIL bp_rvalid%0d got %0b want %0b", c, res_valid, exp_rvalid); end
            if (exp_rvalid) begin
                nvec++; if (res !== head_result() || res_tag !== q[0].tag) begin nerr++; $display("FAIL bp_order%0d got %h/%0d want %h/%0d", c, res, res_tag, head_result(), q[0].tag); end
            end
            if (res_valid) n_out++;
            if (core_ready) accepted++;
            advance();
            if (accepted >= 3) core_valid = 0;
            else if (exp_cready) rand_core();
        end
        nvec++; if (n_out !== 3) begin nerr++; $display("FAIL bp_out_count got %0d want 3", n_out); end
        drain(2);
    endtask

    task automatic test_flush();
        idle();
        res_ready = 0; core_valid = 1; rand_core();
        for (int c = 0; c < 2; c++) begin
            predict(); advance(); rand_core();
        end
        flush = 1; fma_valid = 1; rand_fma();
        predict(); #1;
        nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL flush_pre_valid got %0b want 1", res_valid); end
        nvec++; if (core_ready !== 1'b0 || fma_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready got %0b%0b want 00", core_ready, fma_ready); end
        advance();
        idle();
        core_valid = 1; rand_core();
        predict(); #1;
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL flush_post_valid got %0b want 0", res_valid); end
        advance();
        idle();
        predict(); #1;
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL flush_lat1 got %0b want 0", res_valid); end
        advance();
        predict(); #1;
        nvec++; if (res_valid !== 1'b1 || res !== head_result()) begin nerr++; $display("FAIL flush_lat2 got v%0b %h want v1 %h", res_valid, res, head_result()); end
        advance();
        drain(2);
    endtask

    task automatic test_async_reset();
        apply_reset();
        core_valid = 1; fma_valid = 1;
        for (int c = 0; c < 3; c++) begin
            rand_core(); rand_fma();
            predict(); #1;
            if (c == 2) begin
                nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL areset_pre_valid got %0b want 1", res_valid); end
            end
            advance();
        end
        #2;
        rstn = 0;
        #1;
        nvec++; if (res_valid !== 1'b0 || res !== 32'd0) begin nerr++; $display("FAIL areset_immediate got v%0b %h want v0 0", res_valid, res); end
        nvec++; if (add_a !== 32'd0 || add_isfma !== 1'b0) begin nerr++; $display("FAIL areset_add got %h %0b want 0 0", add_a, add_isfma); end
        idle();
        @(posedge clk);
        @(negedge clk);
        rstn = 1;
        model_reset();
        core_valid = 1; fma_valid = 1; rand_core(); rand_fma();
        predict(); #1;
        nvec++; if (fma_ready !== 1'b1 || core_ready !== 1'b0) begin nerr++; $display("FAIL areset_first_tie got fma %0b core %0b want fma 1 core 0", fma_ready, core_ready); end
        advance();
        drain(3);
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            core_valid = ($urandom_range(0, 3) != 0);
            fma_valid  = ($urandom_range(0, 2) != 0);
            res_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            rand_core(); rand_fma();
            if ($urandom_range(0, 3) == 0) core_b[30:23] = 8'hFF;
            predict(); #1;
            nvec++; if (core_ready !== exp_cready || fma_ready !== exp_fready) begin nerr++; $display("FAIL rnd_ready c%0d got %0b%0b want %0b%0b", c, core_ready, fma_ready, exp_cready, exp_fready); end
            nvec++; if (res_valid !== exp_rvalid) begin nerr++; $display("FAIL rnd_rvalid c%0d got %0b want %0b", c, res_valid, exp_rvalid); end
            if (exp_rvalid) begin
                nvec++; if (res !== head_result() || res_tag !== q[0].tag || res_src !== q[0].src) begin nerr++; $display("FAIL rnd_res c%0d got %h/%0d/%0b want %h/%0d/%0b", c, res, res_tag, res_src, head_result(), q[0].tag, q[0].src); end
            end
            nvec++; if (add_a !== last_acc.a || add_b !== last_acc.b || add_rm !== last_acc.rm || add_isfma !== last_acc.f || add_inf !== last_acc.inf) begin nerr++; $display("FAIL rnd_add c%0d got %h %h %0d %0b%0b want %h %h %0d %0b%0b", c, add_a, add_b, add_rm, add_isfma, add_inf, last_acc.a, last_acc.b, last_acc.rm, last_acc.f, last_acc.inf); end
            advance();
        end
        drain(3);
    endtask

    initial begin
        idle();
        model_reset();
        apply_reset();
        test_reset();
        test_single_fadd();
        test_fsub();
        test_tie();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fadd_sched.md
Name: fadd_sched

Overview:
- Arbitrates and sequences the single shared FP adder datapath between two requesters:
  - the core FP issue path (FADD/FSUB);
  - the FMA multiply stage (product + addend).
- Registers operands into the adder, captures the adder's combinational result, and returns it with tag and source over a valid/ready handshake.
- Sits between the FPU issue logic / FMA multiplier and the FP writeback mux.

Parameters:
- FLEN, 32, operand width (32 or 64).
- TAGW, 5, requester tag width (destination register index).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all in-flight operations.
- core_valid_i  in  1  core request valid.
- core_ready_o  out  1  core request accepted this cycle when high with valid.
- core_a_i  in  FLEN  rs1.
- core_b_i  in  FLEN  rs2.
- core_sub_i  in  1  1 = FSUB.
- core_rm_i  in  3  resolved rounding mode.
- core_tag_i  in  TAGW  tag.
- fma_valid_i  in  1  FMA request valid.
- fma_ready_o  out  1  FMA request accepted.
- fma_a_i  in  FLEN  addend.
- fma_b_i  in  FLEN  rounded product.
- fma_rm_i  in  3  rounding mode.
- fma_prodInf_i  in  1  product infinity came from an infinite multiplicand.
- fma_tag_i  in  TAGW  tag.
- add_a_o  out  FLEN  adder operand 1.
- add_b_o  out  FLEN  adder operand 2.
- add_rm_o  out  3  adder rounding mode.
- add_isFma_o  out  1  adder FMA mode.
- add_rs1rs2Inf_o  out  1  adder infinity qualifier.
- add_result_i  in  FLEN  combinational adder result.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer ready.
- res_o  out  FLEN  result.
- res_tag_o  out  TAGW  result tag.
- res_src_o  out  1  0 = core, 1 = FMA.

Behaviour:
- Pipeline structure: two stages.
  - S1: operand register, drives add_* outputs.
  - S2: result register, drives res_*.
  - Each stage has a valid bit; s1 also holds tag and source.
- Reset (rstn_i low, asynchronous):
  - valid1 = valid2 = 0; res_valid_o = 0.
  - All add_*, res_o, res_tag_o, res_src_o = 0.
  - lastGrant = core (0).
- Advance rules:
  - adv2 = !valid2 || res_ready_i.
  - adv1 = !valid1 || adv2.
  - core_ready_o and fma_ready_o are combinational from adv1 and the grant; a requester's ready is never high unless it is granted.
- Arbitration, evaluated only when adv1:
  - Exactly one valid requester: grant it.
  - Both valid: grant the requester != lastGrant. After reset, FMA wins the first tie.
  - lastGrant updates only on an actual accept.
- Accept (granted valid & adv1), S1 loads:
  - Core accept:
    - add_a_o = core_a_i; add_rm_o = core_rm_i; add_isFma_o = 0; add_rs1rs2Inf_o = 0.
    - add_b_o = core_b_i with bit FLEN-1 inverted when core_sub_i = 1, except when core_b_i is NaN (exponent all ones, mantissa != 0). A NaN operand passes unmodified.
  - FMA accept:
    - add_a_o = fma_a_i; add_b_o = fma_b_i; add_rm_o = fma_rm_i.
    - add_isFma_o = 1; add_rs1rs2Inf_o = fma_prodInf_i.
- S1 → S2: when valid1 & adv2, S2 captures add_result_i, tag and src; valid2 = 1.
  - If adv1 but no accept, valid1 clears.
  - S1 operand registers hold their value when idle; they are not cleared.
- Output:
  - res_* is stable while res_valid_o & !res_ready_i.
  - valid2 clears on handshake unless S1 refills it the same cycle.
- Latency and throughput:
  - Accept in cycle N gives res_valid_o in cycle N+2 when unstalled.
  - Throughput is 1 per cycle.
  - A back-to-back stream is never bubbled by the controller.
- Full stall: valid1 & valid2 & !res_ready_i gives both ready outputs = 0. Nothing is dropped; S1 contents are retained.
- Flush:
  - flush_i = 1 clears valid1 and valid2 next edge.
  - Both ready outputs are 0 during the flush cycle, so no accept occurs.
  - lastGrant is unchanged.
  - flush_i has priority over every other update.
- Reset mid-operation: all in-flight results are discarded immediately; outputs are as at reset.

Test Plan:
- Single core FADD: core_a = 0x3F800000, core_b = 0x40000000, rm = 0, adder model returns 0x40400000 → res_valid in cycle N+2, res_o = 0x40400000, src = 0, tag echoed.
- FSUB sign handling:
  - core_sub = 1, b = 0x40000000 → add_b_o = 0xC0000000.
  - b = 0x7FC00001 → add_b_o = 0x7FC00001, unchanged.
- Tie arbitration: both valid for 4 cycles after reset → grant order FMA, core, FMA, core. add_isFma_o toggles 1,0,1,0 and each FMA issue carries fma_prodInf_i.
- Back-pressure: hold res_ready_i = 0 with 3 queued core requests → exactly 2 accepted, ready = 0 thereafter. Release res_ready_i → results emerge in order, res_o stable while stalled.
- Flush: flush_i pulsed with both stages valid → res_valid_o = 0 next cycle. No accept occurs in the flush cycle; the next request has latency 2.
- Async reset: assert rstn_i low mid-stream between clock edges → res_valid_o = 0 immediately. After release, the first tie is granted to FMA.
